mult_div: RTL and testbench

Sequential signed multiply/divide unit that answers the CPU datapath's Div_Mult_Ctrl request and returns the 64-bit result that feeds the HI and LO registers. The CPU starts an operation with a one-cycle start pulse and samples hi_out/lo_out when done is high. The CPU's HI/LO write signal is driven from done. The CPU raises its divide-by-zero exception (EPC path, vector 253–255) from div0.
- Multiply: radix-2 Booth, 32 iterations.
- Divide: restoring, on magnitudes, with sign fix-up.

---
 rtl/mult_div_pkg.sv | 18 +
 rtl/mult_div_restore_step.sv | 30 +++
 rtl/mult_div.sv | 159 +++++++++++++++
 tb/tb_mult_div.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared constants for the sequential signed multiply/divide unit:
// FSM state encoding, operation codes and the iteration counter sizing.
package mult_div_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MULT   = 2'd1;
  localparam logic [1:0] S_DIV    = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // One extra bit so the counter can hold the full iteration count.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/mult_div_restore_step.sv
// One restoring-division iteration on magnitudes: shift R:Q left, trial
// subtract the divisor, keep the result and set the quotient bit if non-negative.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_r,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH:0]   o_r,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH:0] w_shift_r;
  logic [WIDTH:0] w_trial;

  // R stays below |d| <= 2^(WIDTH-1), so the shifted value fits WIDTH bits and
  // the MSB of the WIDTH+1-bit trial is a true sign bit.
  assign w_shift_r = {i_r[WIDTH-1:0], i_q[WIDTH-1]};
  assign w_trial   = w_shift_r - {1'b0, i_d};

  always_comb begin
    o_r = w_shift_r;
    o_q = {i_q[WIDTH-2:0], 1'b0};
    if (!w_trial[WIDTH]) begin
      o_r = w_trial;
      o_q = {i_q[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mult_div.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring) unit that
// produces the HI/LO result pair; one-cycle done pulse, div0 flag for x/0.
module mult_div
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic [1:0]       dbg_state
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_op;
  logic [WIDTH:0]   r_acc;   // Booth accumulator, or partial remainder R
  logic [WIDTH-1:0] r_q;     // multiplier / quotient shift register
  logic             r_qm1;
  logic [WIDTH-1:0] r_m;     // multiplicand, or divisor magnitude
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_div0_flag;
  logic             r_busy;
  logic             r_done;
  logic             r_div0;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_m_ext;
  logic [WIDTH:0]   w_booth_sum;
  logic [WIDTH:0]   w_div_r;
  logic [WIDTH-1:0] w_div_q;

  // Negating the most negative value yields the same bit pattern, which is
  // exactly its unsigned magnitude.
  assign w_a_mag = a_in[WIDTH-1] ? (-a_in) : a_in;
  assign w_b_mag = b_in[WIDTH-1] ? (-b_in) : b_in;
  assign w_m_ext = {r_m[WIDTH-1], r_m};

  always_comb begin
    w_booth_sum = r_acc;
    case ({r_q[0], r_qm1})
      2'b01:   w_booth_sum = r_acc + w_m_ext;
      2'b10:   w_booth_sum = r_acc - w_m_ext;
      default: w_booth_sum = r_acc;
    endcase
  end

  div_restore_step #(.WIDTH(WIDTH)) u_div_step (
    .i_r (r_acc),
    .i_q (r_q),
    .i_d (r_m),
    .o_r (w_div_r),
    .o_q (w_div_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op        <= OP_MULT;
      r_acc       <= '0;
      r_q         <= '0;
      r_qm1       <= 1'b0;
      r_m         <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_div0_flag <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_div0      <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else begin
      r_done <= 1'b0;
      r_div0 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy      <= 1'b1;
            r_cnt       <= '0;
            r_op        <= op;
            r_acc       <= '0;
            r_qm1       <= 1'b0;
            r_div0_flag <= 1'b0;
            if (op == OP_MULT) begin
              r_q     <= b_in;
              r_m     <= a_in;
              r_state <= S_MULT;
            end else begin
              r_q     <= w_a_mag;
              r_m     <= w_b_mag;
              r_q_neg <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
              r_r_neg <= a_in[WIDTH-1];
              if (b_in == '0) begin
                r_div0_flag <= 1'b1;
                r_state     <= S_FINISH;
              end else begin
                r_state <= S_DIV;
              end
            end
          end
        end
        S_MULT: begin
          // Arithmetic shift right of acc:Q:q_-1 after the add/subtract.
          r_acc <= {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
          r_q   <= {w_booth_sum[0], r_q[WIDTH-1:1]};
          r_qm1 <= r_q[0];
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= S_FINISH;
        end
        S_DIV: begin
          r_acc <= w_div_r;
          r_q   <= w_div_q;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= S_FINISH;
        end
        S_FINISH: begin
          r_done  <= 1'b1;
          r_div0  <= r_div0_flag;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
          if (!r_div0_flag) begin
            if (r_op == OP_MULT) begin
              r_hi <= r_acc[WIDTH-1:0];
              r_lo <= r_q;
            end else begin
              r_hi <= r_r_neg ? (-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
              r_lo <= r_q_neg ? (-r_q) : r_q;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign div0      = r_div0;
  assign hi_out    = r_hi;
  assign lo_out    = r_lo;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mult_div.sv
// Self-checking bench for mult_div: directed corner cases plus random MULT/DIV
// traffic, scored against a 64-bit integer arithmetic reference model.
module tb_mult_div;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic        div0;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;
  logic [64:0] exp_q[$];

  mult_div #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .div0      (div0),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: whole-operation arithmetic on 64-bit signed integers.
  function automatic logic [64:0] model(input logic o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] pv, qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == 1'b0) begin
      p  = sa * sb;
      pv = p;
      return {1'b0, pv};
    end else if (b == 32'd0) begin
      return {1'b1, last_hi, last_lo};
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      qv = q;
      rv = r;
      return {1'b0, rv[31:0], qv[31:0]};
    end
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge; raises start so the next posedge accepts it.
  task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, input string tag);
    logic [64:0] e;
    int lat, busy_cnt, exp_lat;
    e = model(o, a, b);
    exp_q.push_back(e);
    if (!e[64]) begin
      last_hi = e[63:32];
      last_lo = e[31:0];
    end
    exp_lat  = (o && b == 32'd0) ? 1 : 33;
    start    = 1'b1;
    op       = o;
    a_in     = a;
    b_in     = b;
    lat      = -1;
    busy_cnt = 0;
    for (int j = 0; j < 120; j++) begin
      @(negedge clk);
      if (j == 0) begin
        op   = logic'($urandom_range(0, 1));
        a_in = $urandom;
        b_in = $urandom;
        check({tag, "_busy_on_accept"}, {63'd0, busy}, 64'd1);
        check({tag, "_done_low_on_accept"}, {63'd0, done}, 64'd0);
      end
      if (disturb && (j == 5 || j == 20)) begin
        start = 1'b1;
        op    = logic'($urandom_range(0, 1));
        a_in  = $urandom;
        b_in  = $urandom;
      end else begin
        start = 1'b0;
      end
      if (busy) busy_cnt++;
      if (done) begin
        lat = j;
        break;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
    check({tag, "_busy_low_at_done"}, {63'd0, busy}, 64'd0);
    e = exp_q.pop_front();
    check({tag, "_div0"}, {63'd0, div0}, {63'd0, e[64]});
    check({tag, "_hi"}, {32'd0, hi_out}, {32'd0, e[63:32]});
    check({tag, "_lo"}, {32'd0, lo_out}, {32'd0, e[31:0]});
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] specials[5];
    specials = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_div0", {63'd0, div0}, 64'd0);
    check("rst_hi", {32'd0, hi_out}, 64'd0);
    check("rst_lo", {32'd0, lo_out}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases, issued back-to-back on the done-drop edge.
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mul_m1_m1");
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, "mul_min_min");
    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, "mul_7_m3");
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
    run_op(1'b1, 32'd100, 32'd7, 1'b0, "div_100_7");
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0, "div_m100_7");
    run_op(1'b1, 32'd100, 32'hFFFF_FFF9, 1'b0, "div_100_m7");
    run_op(1'b0, 32'h1234_5678, 32'h0FED_CBA9, 1'b0, "mul_prep");
    run_op(1'b1, 32'd5, 32'd0, 1'b0, "div_by_zero");
    run_op(1'b0, 32'h89AB_CDEF, 32'h7654_3210, 1'b1, "mul_disturbed");
    run_op(1'b0, 32'h89AB_CDEF, 32'h7654_3210, 1'b0, "mul_undisturbed");
    run_op(1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1, "div_disturbed");

    // Asynchronous reset in the middle of a divide.
    start = 1'b1;
    op    = 1'b1;
    a_in  = 32'd1000;
    b_in  = 32'd7;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_done", {63'd0, done}, 64'd0);
    check("mid_rst_div0", {63'd0, div0}, 64'd0);
    check("mid_rst_hi", {32'd0, hi_out}, 64'd0);
    check("mid_rst_lo", {32'd0, lo_out}, 64'd0);
    check("mid_rst_state", {62'd0, dbg_state}, 64'd0);
    last_hi = '0;
    last_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_op(1'b0, 32'd3, 32'd4, 1'b0, "mul_3_4_after_rst");
    run_op(1'b1, 32'd9, 32'd0, 1'b0, "div0_keeps_12");

    // Random traffic.
    for (int k = 0; k < 30; k++) begin
      run_op(logic'($urandom_range(0, 1)), pick_operand(), pick_operand(),
             bit'($urandom_range(0, 1)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
